// File: rtl/score_scan_display.sv
// score_scan_display: two-player score driver for a multiplexed seven-segment
// display. Scores are converted to BCD by a sequential double-dabble engine,
// then scanned one digit per prescaler step with leading-zero blanking and a
// per-player goal blink.
//
// Handshake: i_load is a one-cycle request that is accepted only while
// o_busy = 0; while o_busy = 1 any i_load is dropped (no queueing, no restart).
// o_busy falls on the same edge that commits the new digits to the display.
module score_scan_display #(
    parameter int DIGITS       = 3,
    parameter int SCORE_W      = 8,
    parameter int SCAN_DIV     = 250000,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [SCORE_W-1:0]    i_score_player_1,
    input  logic [SCORE_W-1:0]    i_score_player_2,
    input  logic                  i_load,
    input  logic                  i_goal_player_1,
    input  logic                  i_goal_player_2,
    output logic [6:0]            o_data,
    output logic [2*DIGITS-1:0]   o_comm,
    output logic                  o_busy,
    output logic [1:0]            o_dbg_state
);

    localparam int NDIG    = 2 * DIGITS;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STEP_W  = $clog2(SCORE_W + 1);
    localparam int BLK_W   = $clog2(BLINK_FRAMES + 1);
    localparam int MAX_VAL = 10 ** DIGITS - 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Clamp a score to the largest value the digits can show (all 9s).
    function automatic logic [SCORE_W-1:0] f_sat(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        if (64'(v) > 64'(MAX_VAL)) r = SCORE_W'(MAX_VAL);
        else                       r = v;
        return r;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] f_add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < DIGITS; k++) begin
            if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Active-high segment pattern, bit0 = a ... bit6 = g.
    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    state_t               r_state;
    logic [STEP_W-1:0]    r_step_cnt;
    logic [SCORE_W-1:0]   r_bin_1;
    logic [SCORE_W-1:0]   r_bin_2;
    logic [BCD_W-1:0]     r_bcd_1;
    logic [BCD_W-1:0]     r_bcd_2;
    logic [BCD_W-1:0]     r_disp_1;
    logic [BCD_W-1:0]     r_disp_2;
    logic                 r_busy;

    logic [PRE_W-1:0]     r_presc;
    logic [IDX_W-1:0]     r_idx;
    logic [BLK_W-1:0]     r_blink_1;
    logic [BLK_W-1:0]     r_blink_2;
    logic [NDIG-1:0]      r_comm;
    logic [6:0]           r_data;

    logic [BCD_W-1:0]     w_adj_1;
    logic [BCD_W-1:0]     w_adj_2;
    logic                 w_step;
    logic                 w_last_idx;
    logic                 w_frame_tick;
    logic [IDX_W-1:0]     w_idx_next;
    logic                 w_blank_1;
    logic                 w_blank_2;
    logic [NDIG-1:0]      w_comm_next;
    logic [BCD_W-1:0]     w_sel_bcd;
    logic [IDX_W-1:0]     w_pos;
    logic                 w_sel_blank;
    logic [BCD_W-1:0]     w_upper;
    logic                 w_lz;
    logic [6:0]           w_seg;

    assign w_adj_1 = f_add3(r_bcd_1);
    assign w_adj_2 = f_add3(r_bcd_2);

    // Conversion FSM: capture (saturated) scores, SCORE_W dabble steps, commit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_step_cnt <= '0;
            r_bin_1    <= '0;
            r_bin_2    <= '0;
            r_bcd_1    <= '0;
            r_bcd_2    <= '0;
            r_disp_1   <= '0;
            r_disp_2   <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_load) begin
                        r_bin_1    <= f_sat(i_score_player_1);
                        r_bin_2    <= f_sat(i_score_player_2);
                        r_bcd_1    <= '0;
                        r_bcd_2    <= '0;
                        r_step_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_bcd_1    <= {w_adj_1[BCD_W-2:0], r_bin_1[SCORE_W-1]};
                    r_bcd_2    <= {w_adj_2[BCD_W-2:0], r_bin_2[SCORE_W-1]};
                    r_bin_1    <= {r_bin_1[SCORE_W-2:0], 1'b0};
                    r_bin_2    <= {r_bin_2[SCORE_W-2:0], 1'b0};
                    r_step_cnt <= r_step_cnt + STEP_W'(1);
                    if (r_step_cnt == STEP_W'(SCORE_W - 1)) r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_disp_1 <= r_bcd_1;
                    r_disp_2 <= r_bcd_2;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_step       = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_last_idx   = (r_idx == IDX_W'(NDIG - 1));
    assign w_frame_tick = w_step && w_last_idx;
    assign w_idx_next   = w_last_idx ? '0 : r_idx + IDX_W'(1);
    assign w_blank_1    = (r_blink_1 != '0) && r_blink_1[2];
    assign w_blank_2    = (r_blink_2 != '0) && r_blink_2[2];

    // Prescaler: one-cycle step at the terminal count, no derived clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_presc <= '0;
        else if (w_step) r_presc <= '0;
        else             r_presc <= r_presc + PRE_W'(1);
    end

    // Blink counters: a goal reload takes priority over the frame decrement.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_blink_1 <= '0;
            r_blink_2 <= '0;
        end else begin
            if (i_goal_player_1)                        r_blink_1 <= BLK_W'(BLINK_FRAMES);
            else if (w_frame_tick && r_blink_1 != '0)   r_blink_1 <= r_blink_1 - BLK_W'(1);
            if (i_goal_player_2)                        r_blink_2 <= BLK_W'(BLINK_FRAMES);
            else if (w_frame_tick && r_blink_2 != '0)   r_blink_2 <= r_blink_2 - BLK_W'(1);
        end
    end

    // Decode the digit about to be selected: player, position, blanking rules.
    always_comb begin
        w_comm_next = NDIG'(1) << w_idx_next;
        if (w_idx_next < IDX_W'(DIGITS)) begin
            w_sel_bcd   = r_disp_2;
            w_pos       = w_idx_next;
            w_sel_blank = w_blank_2;
        end else begin
            w_sel_bcd   = r_disp_1;
            w_pos       = w_idx_next - IDX_W'(DIGITS);
            w_sel_blank = w_blank_1;
        end
        w_upper = w_sel_bcd >> {w_pos, 2'b00};
        w_lz    = (w_pos != '0) && (w_upper == '0);
        w_seg   = (w_lz || w_sel_blank) ? 7'h00 : f_seg(w_upper[3:0]);
    end

    // Index and both output buses move together on each step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx  <= '0;
            r_comm <= NDIG'(1) ^ {NDIG{ACTIVE_LOW}};
            r_data <= 7'h3F ^ {7{ACTIVE_LOW}};
        end else if (w_step) begin
            r_idx  <= w_idx_next;
            r_comm <= w_comm_next ^ {NDIG{ACTIVE_LOW}};
            r_data <= w_seg ^ {7{ACTIVE_LOW}};
        end
    end

    assign o_comm      = r_comm;
    assign o_data      = r_data;
    assign o_busy      = r_busy;
    assign o_dbg_state = r_state;

endmodule
